// File: rtl/td_delta_gen.sv
// td_delta_gen: TD error generator, delta = sat16(reward + floor(GAMMA * max(q_next)) - qpred) in signed Q6.10.
module td_delta_gen #(
  parameter int                 NUM_ACT = 4,
  parameter logic signed [15:0] GAMMA   = 16'sd922
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] reward,
  input  logic signed [15:0] qpred,
  input  logic signed [15:0] q_in,
  input  logic               q_valid,
  output logic               busy,
  output logic signed [15:0] delta,
  output logic [3:0]         step,
  output logic [3:0]         controller,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, MAX, MUL, SUM, OUT} state_t;
  state_t state, nxt;
  logic signed [15:0] rew, qp, mx, gmax, gprod, sat;
  logic signed [17:0] sum;
  logic [3:0] cnt;
  logic last_beat;
  assign last_beat = q_valid && cnt == 4'(NUM_ACT - 1);
  // Only the low 26 product bits matter; >>> 10 floors toward minus infinity.
  assign gprod = 16'((26'(GAMMA) * 26'(mx)) >>> 10);
  assign sum = 18'(rew) + 18'(gmax) - 18'(qp);
  assign sat = sum > 18'sd32767 ? 16'sh7fff : sum < -18'sd32768 ? 16'sh8000 : sum[15:0];
  assign busy = state != IDLE;
  assign done = state == OUT;
  assign controller = done ? 4'd9 : 4'd0;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? MAX : IDLE;
      MAX:     nxt = last_beat ? MUL : MAX;
      MUL:     nxt = SUM;
      SUM:     nxt = OUT;
      OUT:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rew   <= '0;
      qp    <= '0;
      mx    <= '0;
      gmax  <= '0;
      cnt   <= '0;
      delta <= '0;
      step  <= '0;
    end else begin
      if (state == IDLE && start) begin
        rew <= reward;
        qp  <= qpred;
        cnt <= '0;
      end
      if (state == MAX && q_valid) begin
        mx  <= (cnt == 4'd0 || q_in > mx) ? q_in : mx;
        cnt <= cnt + 4'd1;
      end
      if (state == MUL) gmax <= gprod;
      if (state == SUM) delta <= sat;
      if (state == OUT) step <= step == 4'd15 ? 4'd1 : step + 4'd1;
    end
  end
endmodule

// File: tb/tb_td_delta_gen.sv
// tb_td_delta_gen: random and directed checks of td_delta_gen against an arithmetic TD-error model.
module tb_td_delta_gen;
  logic clk = 0, rst = 1, start = 0, q_valid = 0;
  logic signed [15:0] reward = 0, qpred = 0, q_in = 0;
  logic busy, done;
  logic signed [15:0] delta;
  logic [3:0] step, controller;
  int checks = 0, errors = 0;
  int n_upd = 0, last_delta = 0;
  int beats[4];

  td_delta_gen dut (
    .clk(clk), .rst(rst), .start(start), .reward(reward), .qpred(qpred),
    .q_in(q_in), .q_valid(q_valid), .busy(busy), .delta(delta), .step(step),
    .controller(controller), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_step();
    return n_upd == 0 ? 0 : (n_upd - 1) % 15 + 1;
  endfunction

  function automatic int model_delta(input int r, input int q);
    int m, p, gm, d;
    m = beats[0];
    foreach (beats[i]) if (beats[i] > m) m = beats[i];
    p  = 922 * m;
    gm = p >>> 10;
    d  = r + gm - q;
    return d > 32767 ? 32767 : d < -32768 ? -32768 : d;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_delta"}, int'(delta), 0);
    chk({tag, "_step"}, int'(step), 0);
    chk({tag, "_ctrl"}, int'(controller), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge after OUT.
  task automatic update(input int r, input int q, input int st_at, input int st_len, input bit spam);
    int d;
    d = model_delta(r, q);
    start = 1; reward = 16'(r); qpred = 16'(q);
    @(negedge clk);
    start = 0;
    chk("busy_max", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      if (i == st_at)
        repeat (st_len) begin
          q_valid = 0; q_in = 16'sh7fff; start = spam; reward = 16'sh7fff; qpred = 16'sh8000;
          @(negedge clk);
          chk("stall_busy", int'(busy), 1);
        end
      start = 0; q_valid = 1; q_in = 16'(beats[i]);
      @(negedge clk);
    end
    q_valid = spam; q_in = 16'sh7fff; start = spam; reward = 16'sh7fff;
    chk("mul_done", int'(done), 0);
    chk("mul_delta", int'(delta), last_delta);
    @(negedge clk);
    chk("sum_done", int'(done), 0);
    chk("sum_ctrl", int'(controller), 0);
    @(negedge clk);
    n_upd++;
    chk("out_done", int'(done), 1);
    chk("out_ctrl", int'(controller), 9);
    chk("out_delta", int'(delta), d);
    @(negedge clk);
    start = 0; q_valid = 0;
    chk("idle_done", int'(done), 0);
    chk("idle_ctrl", int'(controller), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_step", int'(step), exp_step());
    chk("idle_delta", int'(delta), d);
    last_delta = d;
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    n_upd = 0; last_delta = 0;
  endtask

  initial begin
    do_reset();
    check_reset("rst");

    beats = '{256, 768, -100, 512};
    update(1024, 512, 9, 0, 0);
    chk("d_basic", last_delta, 1203);
    chk("step_basic", int'(step), 1);

    beats = '{-1, -1, -1, -1};
    update(0, 0, 9, 0, 0);
    chk("d_floor", int'(delta), -1);

    beats = '{32767, 32767, 32767, 32767};
    update(32767, -32768, 9, 0, 0);
    chk("d_satpos", int'(delta), 32767);
    beats = '{-32768, -32768, -32768, -32768};
    update(-32768, 32767, 9, 0, 0);
    chk("d_satneg", int'(delta), -32768);

    beats = '{100, -200, 3000, 50};
    update(-500, 700, 2, 3, 1);
    chk("stall_step", int'(step), 5);

    do_reset();
    check_reset("rst2");
    for (int k = 0; k < 16; k++) begin
      foreach (beats[i]) beats[i] = rnd16();
      update(rnd16(), rnd16(), int'($urandom_range(5)), int'($urandom_range(3)), 1'($urandom_range(1)));
    end
    chk("wrap_step", int'(step), 1);

    beats = '{10, 20, 30, 40};
    start = 1; reward = 16'sd1000; qpred = 16'sd0;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 2; i++) begin
      q_valid = 1; q_in = 16'(beats[i]);
      @(negedge clk);
    end
    q_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_upd = 0; last_delta = 0;
    check_reset("rst_mid");
    repeat (2) @(negedge clk);
    check_reset("rst_idle");
    update(2048, -1024, 9, 0, 0);
    chk("post_rst_step", int'(step), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/td_delta_gen.md
TD_DELTA_GEN -- requirements
Module: td_delta_gen

Interface
REQ-001 Parameter NUM_ACT, default 4: number of next-state Q beats per update, range 2..15.
REQ-002 Parameter GAMMA, default 16'sd922: discount factor, signed Q6.10 (about 0.9).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin an update; honoured only in IDLE.
REQ-006 reward  input  16  signed Q6.10 reward; captured on accepted start.
REQ-007 qpred  input  16  signed Q6.10 predicted Q of the taken action; captured on accepted start.
REQ-008 q_in  input  16  signed Q6.10 next-state Q value beat.
REQ-009 q_valid  input  1  q_in is valid; consumed only in MAX state.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 delta  output  16  signed Q6.10 TD error, registered; holds its value between updates.
REQ-012 step  output  4  completed-update counter; nonzero after the first update.
REQ-013 controller  output  4  phase code; 4'd9 in OUT, otherwise 4'd0.
REQ-014 done  output  1  one-cycle pulse in OUT.

Function
REQ-015 FSM states: IDLE, MAX, MUL, SUM, OUT.
REQ-016 IDLE: on start=1, capture reward and qpred, clear the beat counter, and go to MAX.
REQ-017 MAX: each cycle with q_valid=1 accepts one beat; cycles with q_valid=0 stall with no state change.
REQ-018 MAX: the first beat loads the running max; each later beat replaces it when q_in > max (signed compare).
REQ-019 MAX: after the NUM_ACT-th accepted beat, go to MUL.
REQ-020 MUL: 32-bit signed product = GAMMA * max; register product bits [25:10] as gmax (floor, no rounding); go to SUM.
REQ-021 SUM: compute reward + gmax - qpred sign-extended to 18 bits.
REQ-022 SUM: saturate the result to [-32768, 32767] and write it to delta; go to OUT.
REQ-023 OUT: controller=4'd9 and done=1 for exactly one cycle; step increments; next state IDLE.
REQ-024 step wraps 15 -> 1, never back to 0 after the first update.
REQ-025 Latency: done is high exactly 3 cycles after the clock edge that accepts the last q beat; start-to-done is NUM_ACT+3 cycles minimum.
REQ-026 start outside IDLE is ignored (no recapture, no restart); q_valid outside MAX is ignored.
REQ-027 start in the OUT cycle is ignored; start in the following IDLE cycle is accepted, giving back-to-back updates.
REQ-028 delta changes only in SUM; controller is 4'd0 in all states except OUT.

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE, delta=0, step=0, controller=0, done=0, busy=0, and max, gmax and the beat counter cleared.
REQ-030 rst takes priority over all inputs, including mid-update; the partial update is discarded and step is not incremented.

Verification
REQ-031 reward=1024, qpred=512, beats {256,768,-100,512} -> max=768, gmax=691, delta=1203, controller=9 for one cycle, step=1.
REQ-032 All beats -1, reward=0, qpred=0 -> gmax=-1 (floor), delta=-1 (16'hFFFF).
REQ-033 reward=32767, beats all 32767, qpred=-32768 -> delta saturates to 32767; repeat with reward=-32768, beats all -32768, qpred=32767 -> delta=-32768.
REQ-034 q_valid deasserted for 3 cycles between beats 2 and 3, plus start pulses while busy -> result unchanged, done exactly 3 cycles after the 4th beat, no extra update.
REQ-035 16 back-to-back updates -> step sequence 1..15 then 1; controller=9 exactly once per update.
REQ-036 rst asserted after beat 2 -> all outputs at reset values next cycle; the next full update completes normally with step=1.
